// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared funct encodings, FSM states and helpers for the multi-cycle ALU
//
// Contents:
//   F_*              6-bit funct encodings understood by alu_multicycle
//   state_e          mul/div engine states (IDLE, RUN, DONE)
//   muldiv_op_e      operation handed from the top to the iterative engine
//   is_multicycle()  1 when a funct is serviced by the mul/div engine
//   funct_to_op()    maps a multi-cycle funct onto the engine operation
package alu_pkg;

    localparam logic [5:0] F_ADD   = 6'b000001;
    localparam logic [5:0] F_ADD_B = 6'b001001;
    localparam logic [5:0] F_ADD_C = 6'b001010;
    localparam logic [5:0] F_SUB   = 6'b000010;
    localparam logic [5:0] F_AND   = 6'b000101;
    localparam logic [5:0] F_OR    = 6'b000110;
    localparam logic [5:0] F_XOR   = 6'b010010;
    localparam logic [5:0] F_SLL   = 6'b000111;
    localparam logic [5:0] F_SRA   = 6'b001000;
    localparam logic [5:0] F_SRL   = 6'b010001;
    localparam logic [5:0] F_SOV   = 6'b001110;
    localparam logic [5:0] F_MULU  = 6'b000011;
    localparam logic [5:0] F_MULS  = 6'b001111;
    localparam logic [5:0] F_DIVU  = 6'b000100;
    localparam logic [5:0] F_DIVS  = 6'b010000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_MULU,
        OP_MULS,
        OP_DIVU,
        OP_DIVS
    } muldiv_op_e;

    function automatic logic is_multicycle(input logic [5:0] funct);
        logic mc;
        case (funct)
            F_MULU, F_MULS, F_DIVU, F_DIVS: mc = 1'b1;
            default:                        mc = 1'b0;
        endcase
        return mc;
    endfunction

    function automatic muldiv_op_e funct_to_op(input logic [5:0] funct);
        muldiv_op_e op;
        case (funct)
            F_MULS:  op = OP_MULS;
            F_DIVU:  op = OP_DIVU;
            F_DIVS:  op = OP_DIVS;
            default: op = OP_MULU;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// rtl/seq_muldiv_unit.sv - shared iterative multiply/divide engine with hi/lo result registers
//
// Ports:
//   clk, reset    clock and asynchronous active-low reset
//   start         launch request, only honoured in IDLE
//   op            operation to launch (mulu/muls/divu/divs)
//   a, b          operands (dividend/divisor for divides)
//   hi, lo        result view: fixed-up result while DONE, held registers otherwise
//   done          1 for the single DONE cycle
//   busy          1 in RUN and DONE
//   div_by_zero   sticky flag from the last divide, cleared when a new op is accepted
module seq_muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  muldiv_op_e       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] acc_q;      // partial product high half / partial remainder
    logic [WIDTH-1:0] qreg_q;     // multiplier shifting out / dividend shifting into quotient
    logic [WIDTH-1:0] opnd_b_q;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             mul_q, sign_a_q, sign_b_q, dz_q;

    // Launch-time decode of the incoming operation.
    logic             is_mul, is_signed, sign_a, sign_b, zero_div;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign is_mul    = (op == OP_MULU) || (op == OP_MULS);
    assign is_signed = (op == OP_MULS) || (op == OP_DIVS);
    assign sign_a    = is_signed & a[WIDTH-1];
    assign sign_b    = is_signed & b[WIDTH-1];
    assign mag_a     = sign_a ? -a : a;
    assign mag_b     = sign_b ? -b : b;
    assign zero_div  = !is_mul && (b == '0);

    // One iteration: shift-add for multiply, restoring subtract for divide.
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_acc, step_qreg;

    assign addend    = qreg_q[0] ? opnd_b_q : '0;
    assign mul_sum   = {1'b0, acc_q} + {1'b0, addend};
    assign div_shift = {acc_q, qreg_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_b_q};
    assign div_ge    = ~div_diff[WIDTH];

    always_comb begin
        step_acc  = acc_q;
        step_qreg = qreg_q;
        if (mul_q) begin
            step_acc  = mul_sum[WIDTH:1];
            step_qreg = {mul_sum[0], qreg_q[WIDTH-1:1]};
        end else begin
            step_acc  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_qreg = {qreg_q[WIDTH-2:0], div_ge};
        end
    end

    // Sign fix-up applied to the unsigned magnitude result.
    logic                 neg_result;
    logic [2*WIDTH-1:0]   prod_raw, prod_fix;
    logic [WIDTH-1:0]     res_hi, res_lo;

    assign neg_result = sign_a_q ^ sign_b_q;
    assign prod_raw   = {acc_q, qreg_q};
    assign prod_fix   = neg_result ? -prod_raw : prod_raw;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        if (dz_q) begin
            // acc_q was loaded with the raw dividend for a zero divisor.
            res_hi = '1;
            res_lo = acc_q;
        end else if (mul_q) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else begin
            res_hi = neg_result ? -qreg_q : qreg_q;
            res_lo = sign_a_q ? -acc_q : acc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = zero_div ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            acc_q    <= '0;
            qreg_q   <= '0;
            opnd_b_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mul_q    <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mul_q    <= is_mul;
                        sign_a_q <= sign_a;
                        sign_b_q <= sign_b;
                        dz_q     <= zero_div;
                        opnd_b_q <= mag_b;
                        qreg_q   <= mag_a;
                        acc_q    <= zero_div ? a : '0;
                        count_q  <= zero_div ? '0 : CW'(WIDTH);
                    end
                end
                RUN: begin
                    acc_q   <= step_acc;
                    qreg_q  <= step_qreg;
                    count_q <= count_q - 1'b1;
                end
                DONE: begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
                default: ;
            endcase
        end
    end

    // The finished result is visible in the DONE cycle itself, before it lands in hi_q/lo_q.
    assign hi          = done ? res_hi : hi_q;
    assign lo          = done ? res_lo : lo_q;
    assign div_by_zero = dz_q;

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - datapath ALU: single-cycle simple ops plus iterative mul/div
//
// Ports:
//   clk, reset    clock and asynchronous active-low reset
//   start         mul/div launch request (taken only when the engine is idle)
//   funct         operation select
//   a, b          operands (dividend/divisor for divides)
//   shamt         shift amount
//   c             combinational result for simple ops, hi register for mul/div
//   c_low         lo register (low product half or remainder)
//   ready         result on c/c_low is valid this cycle
//   busy          mul/div engine running
//   div_by_zero   sticky flag from the last divide
module alu_multicycle
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_low,
    output logic             ready,
    output logic             busy,
    output logic             div_by_zero
);

    logic             mc;
    logic [WIDTH-1:0] hi, lo;
    logic             eng_done, eng_busy;
    logic [WIDTH-1:0] simple_res, diff;
    logic             sub_ovf;

    assign mc      = is_multicycle(funct);
    assign diff    = a - b;
    // Signed overflow of a-b: operands of opposite sign and the result sign differs from a.
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        simple_res = '0;
        case (funct)
            F_ADD, F_ADD_B, F_ADD_C: simple_res = a + b;
            F_SUB:                   simple_res = diff;
            F_AND:                   simple_res = a & b;
            F_OR:                    simple_res = a | b;
            F_XOR:                   simple_res = a ^ b;
            F_SLL:                   simple_res = a << shamt;
            F_SRA:                   simple_res = $signed(a) >>> shamt;
            F_SRL:                   simple_res = a >> shamt;
            F_SOV:                   simple_res = {{(WIDTH-1){1'b0}}, sub_ovf};
            default:                 simple_res = '0;
        endcase
    end

    seq_muldiv_unit #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk        (clk),
        .reset      (reset),
        .start      (start & mc),
        .op         (funct_to_op(funct)),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .done       (eng_done),
        .busy       (eng_busy),
        .div_by_zero(div_by_zero)
    );

    assign c     = mc ? hi : simple_res;
    assign c_low = lo;
    assign busy  = eng_busy;
    // For mul/div functs the held hi/lo are valid in IDLE unless a launch is being requested.
    assign ready = !reset || !mc || eng_done || (!eng_busy && !start);

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle with randomized operations
module tb_alu_multicycle;

    localparam int W = 32;

    localparam logic [5:0] T_ADD  = 6'b000001, T_ADD2 = 6'b001001, T_ADD3 = 6'b001010;
    localparam logic [5:0] T_SUB  = 6'b000010, T_AND  = 6'b000101, T_OR   = 6'b000110;
    localparam logic [5:0] T_XOR  = 6'b010010, T_SLL  = 6'b000111, T_SRA  = 6'b001000;
    localparam logic [5:0] T_SRL  = 6'b010001, T_SOV  = 6'b001110;
    localparam logic [5:0] T_MULU = 6'b000011, T_MULS = 6'b001111;
    localparam logic [5:0] T_DIVU = 6'b000100, T_DIVS = 6'b010000;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   funct = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [4:0]   shamt = '0;
    logic [W-1:0] c, c_low;
    logic         ready, busy, div_by_zero;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .funct      (funct),
        .a          (a),
        .b          (b),
        .shamt      (shamt),
        .c          (c),
        .c_low      (c_low),
        .ready      (ready),
        .busy       (busy),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int unsigned  acc_cyc;
        int unsigned  lat;
    } mc_exp_t;

    typedef struct {
        logic [W-1:0] c;
        logic [W-1:0] lo;
    } simple_exp_t;

    mc_exp_t     exp_q[$];
    simple_exp_t simple_q[$];
    mc_exp_t     mon_e;
    simple_exp_t mon_s;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] model_lo = '0;

    logic [5:0] simple_fs [13] = '{T_ADD, T_ADD2, T_ADD3, T_SUB, T_AND, T_OR, T_XOR,
                                   T_SLL, T_SRA, T_SRL, T_SOV, 6'b111111, 6'b000000};
    logic [5:0] mc_fs [4] = '{T_MULU, T_MULS, T_DIVU, T_DIVS};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_simple(input logic [5:0] f, input logic [W-1:0] x,
                                                input logic [W-1:0] y, input logic [4:0] s);
        longint sx, sy, p, t;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = 1;
        for (int i = 0; i < int'(s); i++) p = p * 2;
        t = 0;
        case (f)
            T_ADD, T_ADD2, T_ADD3: t = longint'(x) + longint'(y);
            T_SUB: t = longint'(x) - longint'(y);
            T_AND: return x & y;
            T_OR:  return x | y;
            T_XOR: return x ^ y;
            T_SLL: t = longint'(x) * p;
            T_SRA: begin
                t = sx / p;
                if ((sx % p) != 0 && sx < 0) t = t - 1;
            end
            T_SRL: t = longint'(x) / p;
            T_SOV: t = ((sx - sy) > SMAX || (sx - sy) < SMIN) ? 1 : 0;
            default: t = 0;
        endcase
        u = t;
        return u[W-1:0];
    endfunction

    task automatic ref_muldiv(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                              output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
        longint sx, sy, q, r;
        logic [63:0] p, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        dz = 1'b0;
        hi = '0;
        lo = '0;
        if ((f == T_DIVU || f == T_DIVS) && y == 0) begin
            hi = '1;
            lo = x;
            dz = 1'b1;
        end else begin
            case (f)
                T_MULU: begin
                    p = {32'b0, x} * {32'b0, y};
                    hi = p[63:32];
                    lo = p[31:0];
                end
                T_MULS: begin
                    p = sx * sy;
                    hi = p[63:32];
                    lo = p[31:0];
                end
                T_DIVU: begin
                    hi = x / y;
                    lo = x % y;
                end
                default: begin
                    q = sx / sy;
                    r = sx % sy;
                    uq = q;
                    ur = r;
                    hi = uq[31:0];
                    lo = ur[31:0];
                end
            endcase
        end
    endtask

    // Monitor: consumes expected items whenever the DUT presents a result.
    always @(negedge clk) begin
        if (reset && busy && ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got c=%0h with no pending op", c);
            end else begin
                mon_e = exp_q.pop_front();
                check("mc_hi", c, mon_e.hi);
                check("mc_lo", c_low, mon_e.lo);
                check("mc_dz", div_by_zero, mon_e.dz);
                check("mc_latency", cyc - mon_e.acc_cyc, mon_e.lat);
            end
        end
        if (simple_q.size() > 0) begin
            mon_s = simple_q.pop_front();
            check("simple_c", c, mon_s.c);
            check("simple_ready", ready, 1);
            check("simple_lo_held", c_low, mon_s.lo);
        end
    end

    task automatic do_simple(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [4:0] s);
        @(posedge clk);
        #1;
        funct = f; a = x; b = y; shamt = s; start = 1'b0;
        simple_q.push_back('{c: ref_simple(f, x, y, s), lo: model_lo});
        @(negedge clk);
        #1;
    endtask

    task automatic do_mc(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit disturb);
        logic [W-1:0] eh, el;
        logic         edz;
        bit           finished;
        ref_muldiv(f, x, y, eh, el, edz);
        @(posedge clk);
        #1;
        funct = f; a = x; b = y; start = 1'b1;
        @(negedge clk);
        check("start_ready_low", ready, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back('{hi: eh, lo: el, dz: edz, acc_cyc: cyc, lat: (edz ? 0 : W)});
        check("accept_dz", div_by_zero, edz);
        check("accept_busy", busy, 1);
        if (disturb && !edz) begin
            repeat (3) @(posedge clk);
            #1;
            start = 1'b1;
            a = $urandom;
            b = $urandom;
            funct = mc_fs[$urandom_range(0, 3)];
            repeat (2) @(posedge clk);
            #1;
            start = 1'b0;
        end
        finished = 1'b0;
        for (int k = 0; k < 100 && !finished; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) finished = 1'b1;
        end
        if (!finished) begin
            n_tests++;
            n_fail++;
            $display("FAIL mc_timeout: got busy=%0b pending=%0d expected completion", busy, exp_q.size());
            exp_q.delete();
        end
        check("held_ready", ready, 1);
        check("held_hi", c, eh);
        check("held_lo", c_low, el);
        model_lo = el;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]   f;
        logic [W-1:0] x, y;

        // Reset state
        funct = T_MULU;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_c_low", c_low, 0);
        check("rst_ready", ready, 1);
        check("rst_c_mc", c, 0);
        funct = T_ADD; a = 5; b = 6;
        #1;
        check("rst_c_simple", c, 11);
        funct = T_MULU; start = 1'b1;
        #1;
        check("rst_ready_start", ready, 1);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        do_simple(T_ADD, 32'hFFFFFFFF, 32'd2, 0);
        do_mc(T_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_simple(T_XOR, 32'h1234_5678, 32'h0F0F_0F0F, 0);
        do_mc(T_MULS, -32'sd3, 32'd7, 0);
        do_mc(T_DIVS, -32'sd7, 32'd2, 0);
        do_mc(T_DIVU, 32'd100, 32'd0, 0);
        do_mc(T_MULU, 32'd3, 32'd5, 0);
        do_mc(T_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        do_mc(T_DIVS, -32'sd100, 32'd0, 0);
        do_simple(T_SOV, 32'h8000_0000, 32'd1, 0);
        do_simple(T_SOV, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
        do_simple(T_SOV, 32'h7FFF_FFFF, 32'd1, 0);
        do_simple(T_SRA, 32'h8000_0000, 32'd0, 5'd31);
        do_simple(T_SLL, 32'h8000_0001, 32'd0, 5'd31);
        do_simple(T_SRL, 32'h8000_0000, 32'd0, 5'd31);
        do_simple(6'b111111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                do_simple(simple_fs[$urandom_range(0, 12)], x, y, 5'($urandom_range(0, 31)));
            end else begin
                f = mc_fs[$urandom_range(0, 3)];
                if ($urandom_range(0, 7) == 0) y = 0;
                if (f == T_DIVS && $urandom_range(0, 7) == 0) begin
                    x = 32'h8000_0000;
                    y = 32'hFFFF_FFFF;
                end
                if (f == T_DIVU && $urandom_range(0, 3) == 0) y = y >> $urandom_range(8, 31);
                do_mc(f, x, y, $urandom_range(0, 3) == 0);
            end
        end

        // Reset in the middle of a divide
        @(posedge clk);
        #1;
        funct = T_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_busy_before_reset", busy, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_c_low", c_low, 0);
        check("mid_rst_c", c, 0);
        check("mid_rst_dz", div_by_zero, 0);
        check("mid_rst_ready", ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        do_mc(T_DIVU, 32'd9, 32'd2, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
